// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - write-port arbiter and busy scoreboard for the 32x32 register file
//
// Two writeback sources share the single register-file write port:
//   port 0 = ALU, port 1 = load/multi-cycle unit.
// A per-register busy scoreboard tracks issued-but-unwritten destinations
// so decode can detect RAW hazards on its two source operands.
// Writes to x0 are handshaken normally but never reach the register file.
//
// Build option: RR_ARB_EN
//   defined   - round-robin on contention (port 0 wins the first one after reset)
//   undefined - fixed priority, port 1 always wins contention
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wb0_valid/rd/data, wb0_ready   ALU writeback request and combinational grant
//   wb1_valid/rd/data, wb1_ready   load/mul writeback request and combinational grant
//   iss_valid, iss_rd         decode issues an instruction writing iss_rd
//   chk_rs1, chk_rs2          hazard-check source indices
//   rs1_busy, rs2_busy        combinational busy lookup for the check indices
//   RegWrite, Rd, Write_data  registered register-file write port
//   busy                      registered scoreboard vector
module rf_wb_arbiter #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wb0_valid,
    input  logic [ADDR_W-1:0]   wb0_rd,
    input  logic [DATA_W-1:0]   wb0_data,
    output logic                wb0_ready,
    input  logic                wb1_valid,
    input  logic [ADDR_W-1:0]   wb1_rd,
    input  logic [DATA_W-1:0]   wb1_data,
    output logic                wb1_ready,
    input  logic                iss_valid,
    input  logic [ADDR_W-1:0]   iss_rd,
    input  logic [ADDR_W-1:0]   chk_rs1,
    input  logic [ADDR_W-1:0]   chk_rs2,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic                RegWrite,
    output logic [ADDR_W-1:0]   Rd,
    output logic [DATA_W-1:0]   Write_data,
    output logic [NUM_REGS-1:0] busy
);

    logic                r_reg_write;
    logic [ADDR_W-1:0]   r_rd;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_REGS-1:0] r_busy;

    logic                w_pick0;
    logic                w_gnt0;
    logic                w_gnt1;
    logic                w_xfer;
    logic [ADDR_W-1:0]   w_win_rd;
    logic [DATA_W-1:0]   w_win_data;
    logic [NUM_REGS-1:0] w_busy_next;

`ifdef RR_ARB_EN
    // Remembers the port that made the most recent transfer; on contention
    // the other port wins. Reset to 1 so port 0 wins the first contention.
    logic r_last_grant;

    assign w_pick0 = r_last_grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= 1'b1;
        end else if (w_xfer) begin
            r_last_grant <= w_gnt1;
        end
    end
`else
    // Port 1 always wins contention; bursty load traffic makes starvation
    // of the ALU port acceptable.
    assign w_pick0 = 1'b0;
`endif

    // Grants are mutually exclusive and never raised without a request.
    assign w_gnt0 = wb0_valid & (~wb1_valid | w_pick0);
    assign w_gnt1 = wb1_valid & ~w_gnt0;
    assign w_xfer = w_gnt0 | w_gnt1;

    assign wb0_ready = w_gnt0;
    assign wb1_ready = w_gnt1;

    assign w_win_rd   = w_gnt1 ? wb1_rd   : wb0_rd;
    assign w_win_data = w_gnt1 ? wb1_data : wb0_data;

    // Write port register: one-cycle latency, one write per cycle.
    // An x0 transfer is consumed but produces no write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_write <= 1'b0;
            r_rd        <= '0;
            r_wdata     <= '0;
        end else begin
            r_reg_write <= w_xfer && (w_win_rd != '0);
            if (w_xfer) begin
                r_rd    <= w_win_rd;
                r_wdata <= w_win_data;
            end
        end
    end

    // Scoreboard: clear happens at the end of the RegWrite cycle (the file
    // read is still stale during it); a same-edge issue to the same index
    // overrides the clear because a newer writer is now outstanding.
    always_comb begin
        w_busy_next = r_busy;
        if (r_reg_write) begin
            w_busy_next[r_rd] = 1'b0;
        end
        if (iss_valid && (iss_rd != '0)) begin
            w_busy_next[iss_rd] = 1'b1;
        end
        w_busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    // busy[0] is held at 0, so index 0 naturally reads as not busy.
    assign rs1_busy = r_busy[chk_rs1];
    assign rs2_busy = r_busy[chk_rs2];

    assign RegWrite   = r_reg_write;
    assign Rd         = r_rd;
    assign Write_data = r_wdata;
    assign busy       = r_busy;

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-port arbiter and scoreboard for the 32x32 Register_File. Two writeback sources share the single write port (RegWrite/Rd/Write_data): port 0 is the ALU and port 1 is the load/multi-cycle unit. A per-register busy scoreboard records destinations issued but not yet written, so decode can detect RAW hazards on Rs1/Rs2. Writes to x0 are accepted and discarded.

Parameters:
NUM_REGS, 32, number of architectural registers; must equal 2**ADDR_W.
ADDR_W, 5, register index width.
DATA_W, 32, data width.

Ports:
clk  input  1  clock; all state updates on posedge.
rst  input  1  asynchronous, active-high reset.
wb0_valid  input  1  port 0 (ALU) has a write pending.
wb0_rd  input  ADDR_W  port 0 destination register.
wb0_data  input  DATA_W  port 0 write data.
wb0_ready  output  1  port 0 granted this cycle (combinational).
wb1_valid  input  1  port 1 (load/mul) has a write pending.
wb1_rd  input  ADDR_W  port 1 destination register.
wb1_data  input  DATA_W  port 1 write data.
wb1_ready  output  1  port 1 granted this cycle (combinational).
iss_valid  input  1  decode issues an instruction that writes iss_rd.
iss_rd  input  ADDR_W  issued destination.
chk_rs1  input  ADDR_W  hazard-check source 1.
chk_rs2  input  ADDR_W  hazard-check source 2.
rs1_busy  output  1  busy[chk_rs1] (combinational).
rs2_busy  output  1  busy[chk_rs2] (combinational).
RegWrite  output  1  to Register_File write enable (registered).
Rd  output  ADDR_W  to Register_File write index (registered).
Write_data  output  DATA_W  to Register_File write data (registered).
busy  output  NUM_REGS  scoreboard vector (registered).

Behaviour:
- Reset (async, immediate): RegWrite=0, Rd=0, Write_data=0, busy=0, last_grant=1 (so port 0 wins the first contention). rst mid-transfer: in-flight write dropped, no RegWrite pulse after rst deasserts.
- Handshake: a transfer occurs when wbN_valid and wbN_ready are both high in the same cycle. The requester holds valid/rd/data stable until ready. At most one ready is high per cycle. ready is never high without the matching valid.
- Arbitration: only one valid -> that port is granted. Both valid -> the port given by the Optional Feature is granted. last_grant updates only on a transfer.
- Latency: transfer in cycle T -> RegWrite=1, Rd and Write_data registered from the winner in cycle T+1 -> Register_File is written at the end of T+1. Throughput is one write per cycle. RegWrite=0 in any cycle that follows a cycle with no transfer.
- x0: a transfer with rd=0 is accepted (ready=1) but RegWrite stays 0 in T+1. busy[0] is hardwired 0.
- Scoreboard set: iss_valid and iss_rd!=0 -> busy[iss_rd]<=1 at the edge.
- Scoreboard clear: in a cycle with RegWrite=1, busy[Rd]<=0 at the edge. busy stays 1 during the RegWrite cycle, because the register file read is still stale in that cycle.
- Set and clear of the same index at the same edge -> set wins (a newer writer is outstanding).
- Re-issue to an already-busy rd -> remains 1. There is no count; the pipeline guarantees in-order writes per rd.
- rs1_busy/rs2_busy: pure combinational index of busy. Index 0 always returns 0.

Optional Feature:
RR_ARB_EN
- Defined: round-robin arbitration. On contention, grant the port not in last_grant. Two continuously valid ports alternate 0,1,0,1 starting with port 0 after reset.
- Undefined: fixed priority, port 1 always wins contention. last_grant is unused and is optimised away. Port 0 can starve while port 1 stays valid. This is accepted because load traffic is bursty.

Test Plan:
- Reset: assert rst mid-cycle with wb0_valid=1 -> RegWrite, Rd, Write_data and busy go to 0 immediately, and no RegWrite pulse occurs on the cycle after release.
- Single write: wb0_valid=1, rd=3, data=A5A5A5A5 for one cycle -> wb0_ready=1, next cycle RegWrite=1, Rd=3, Write_data=A5A5A5A5, and a Register_File read of x3 returns A5A5A5A5 afterwards.
- Contention: both ports valid for 4 cycles (wb0 rd=5/data=11111111, wb1 rd=6/data=22222222):
  - With RR_ARB_EN, the grant order is 0,1,0,1.
  - Without it, wb1_ready is high every cycle and wb0_ready stays 0.
- x0 discard: wb1_valid=1, rd=0, data=DEADBEEF -> wb1_ready=1, RegWrite stays 0, and x0 still reads 0.
- Scoreboard: iss_valid with rd=7, then chk_rs1=7 -> rs1_busy=1. Then a wb0 write to 7 -> rs1_busy stays 1 during the RegWrite cycle and reads 0 the following cycle.
- Set/clear collision: RegWrite=1 with Rd=9 in the same cycle as iss_valid with iss_rd=9 -> busy[9] remains 1.
